rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that shares one resource among up to eight requesters. It drives a one-hot grant vector produced by a 3-to-8 decode of the registered grant index, and sequences grants through an IDLE/GRANT/RELEASE state machine. An optional hold-time limit forces a release when a grantee holds the resource too long. It sits between the requester ports and the shared resource's enable/select lines.

---
 rtl/rr_arbiter8.sv | 138 +++++++++++++
 tb/tb_rr_arbiter8.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter sequenced through IDLE/GRANT/RELEASE.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD grant limit and the timeout pulse.
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_RELEASE
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [2:0]  id_q, id_d;
   logic [15:0] req2;
   logic [7:0]  rot;
   logic [2:0]  off;
   logic [2:0]  winner;
   logic        rel_user;
   logic        hold_hit;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD must be within 1..255");
   end

   // Rotate requests so that bit 0 is the requester at ptr; the lowest set bit wins.
   assign req2 = {req, req};
   assign rot  = req2[ptr_q +: 8];

   always_comb begin
      off = '0;
      for (int unsigned j = 8; j > 0; j--) begin
         if (rot[j-1]) off = 3'(j - 1);
      end
   end

   assign winner   = ptr_q + off;
   assign rel_user = done | ~req[id_q];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
   logic       to_q, to_d;

   assign hold_hit = (hold_q == 8'(MAX_HOLD - 1));
`else
   assign hold_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_GRANT;
               id_d    = winner;
            end
         end
         S_GRANT: begin
            if (rel_user || hold_hit) begin
               state_d = S_RELEASE;
               ptr_d   = id_q + 3'd1;
            end
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
         to_q   <= 1'b0;
      end else begin
         hold_q <= hold_d;
         to_q   <= to_d;
      end
   end

   // A user release (done or withdrawal) masks the forced-release flag.
   always_comb begin
      hold_d = hold_q;
      to_d   = 1'b0;
      if (state_q == S_IDLE && (|req)) begin
         hold_d = '0;
      end else if (state_q == S_GRANT) begin
         if (rel_user || hold_hit) begin
            to_d = ~rel_user;
         end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
         end
      end
   end
`endif

   // Output decode
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      timeout   = 1'b0;
      if (state_q == S_GRANT) begin
         gnt_valid = 1'b1;
         gnt[id_q] = 1'b1;
      end
`ifdef ARB_TIMEOUT_EN
      if (state_q == S_RELEASE) timeout = to_q;
`endif
   end

   assign gnt_id = id_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: directed stimulus queues expected outputs,
// a monitor pops and compares them. Timeout scenarios need ARB_TIMEOUT_EN.
module tb_rr_arbiter8;

   typedef struct {
      logic [7:0] g;
      logic [2:0] id;
      logic       v;
      logic       to;
      int         n;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   nstep  = 0;
   event chk_ev;

   rr_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [7:0] g, input logic [2:0] id, input logic v, input logic to);
      exp_t e;
      e.g = g; e.id = id; e.v = v; e.to = to; e.n = nstep;
      nstep++;
      q.push_back(e);
   endtask

   // Drive inputs, take one rising edge, queue the outputs expected after it.
   task automatic step(input logic [7:0] r, input logic d,
                       input logic [7:0] g, input logic [2:0] id, input logic v, input logic to);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
      push(g, id, v, to);
   endtask

   // Monitor: compares on the falling edge, or immediately when poked.
   initial begin
      forever begin
         @(negedge clk or chk_ev);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (gnt !== e.g || gnt_id !== e.id || gnt_valid !== e.v || timeout !== e.to) begin
               errors++;
               $display("FAIL step%0d: got gnt=%h gnt_id=%0d gnt_valid=%b timeout=%b, expected gnt=%h gnt_id=%0d gnt_valid=%b timeout=%b",
                        e.n, gnt, gnt_id, gnt_valid, timeout, e.g, e.id, e.v, e.to);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
      $fatal(1);
   end

   initial begin
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;
      #3;
      push(8'h00, 3'd0, 1'b0, 1'b0);
      -> chk_ev;
      #9 rst = 1'b0;
      @(posedge clk);
      #1;

      // Rotation 0,2,0,2 with req=05 and a 2-cycle bubble
      step(8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
      step(8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'h05, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      step(8'h05, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
      step(8'h05, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
      step(8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
      step(8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'h05, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      step(8'h05, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);

      // Wrap-around: grant 7, then ptr wraps to 0
      step(8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
      step(8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0);
      step(8'h81, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);
      step(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
      step(8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

      // Withdrawal of requester 3
      step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
      step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);

      // Other requests arriving mid-grant do not disturb it; search from ptr=5 wraps to 0
      step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
      step(8'h13, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
      step(8'h13, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0);
      step(8'h13, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
      step(8'h13, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
      step(8'h13, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // Hold limit 4: grant 1 for 4 cycles, timeout pulse, then grant 2
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1);
      step(8'h06, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
      step(8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      // done coincides with the hold limit: release without timeout
      step(8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      step(8'h06, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
`else
      // No hold limit: grant persists well past 4 cycles, no timeout
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h06, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0);
      step(8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
`endif

      // Asynchronous reset mid-grant with req=FF, then first grant is requester 0
      step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
      req = 8'hFF;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      push(8'h00, 3'd0, 1'b0, 1'b0);
      -> chk_ev;
      #1 rst = 1'b0;
      step(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
      step(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      step(8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      step(8'h00, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
